dlsc_pcie_s6_outbound_write_fmt: RTL and testbench

Formats outbound posted Memory Write TLPs for the Spartan-6 PCIe endpoint transmit path. Accepts the credit-checked header (address, length, byte enables) and 32-bit payload stream produced by the outbound write path. Serializes them into a 32-bit TLP word stream with start/end-of-packet markers for the transmit arbiter/TRN adapter. Emits 3DW headers for 32-bit addresses and 4DW headers when address bits above 31 are non-zero.

---
 rtl/dlsc_pcie_s6_outbound_write_fmt.sv | 136 +++++++++++++
 tb/tb_dlsc_pcie_s6_outbound_write_fmt.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dlsc_pcie_s6_outbound_write_fmt.sv
// dlsc_pcie_s6_outbound_write_fmt: serializes posted Memory Write headers and payload into a 32-bit TLP stream
module dlsc_pcie_s6_outbound_write_fmt #(
    parameter int ADDR = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      cfg_bus_number,
    input  logic [4:0]      cfg_device_number,
    input  logic [2:0]      cfg_function_number,
    output logic            wr_tlp_h_ready,
    input  logic            wr_tlp_h_valid,
    input  logic [ADDR-1:2] wr_tlp_h_addr,
    input  logic [9:0]      wr_tlp_h_len,
    input  logic [3:0]      wr_tlp_h_be_first,
    input  logic [3:0]      wr_tlp_h_be_last,
    output logic            wr_tlp_d_ready,
    input  logic            wr_tlp_d_valid,
    input  logic [31:0]     wr_tlp_d_data,
    input  logic            tx_ready,
    output logic            tx_valid,
    output logic [31:0]     tx_data,
    output logic            tx_sof,
    output logic            tx_eof
);
    // DW0 is loaded on the header accept edge, so each state names the word loaded next
    localparam logic [2:0] IDLE = 3'd0, HDR1 = 3'd1, HDR2 = 3'd2, HDR3 = 3'd3, DATA = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [63:2] addr_q, addr_d;
    logic [9:0]  len_q, len_d;
    logic [3:0]  bef_q, bef_d, bel_q, bel_d;
    logic [15:0] rid_q, rid_d;
    logic        hdr4_q, hdr4_d;
    logic [10:0] cnt_q, cnt_d;
    logic        valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
    logic [31:0] data_q, data_d;
    logic [63:2] addr_in;
    logic        adv;

    assign addr_in        = 62'(wr_tlp_h_addr);
    assign adv            = !valid_q | tx_ready;
    assign wr_tlp_h_ready = (state_q == IDLE) & adv;
    assign wr_tlp_d_ready = (state_q == DATA) & adv;
    assign tx_valid       = valid_q;
    assign tx_data        = data_q;
    assign tx_sof         = sof_q;
    assign tx_eof         = eof_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        bef_d   = bef_q;
        bel_d   = bel_q;
        rid_d   = rid_q;
        hdr4_d  = hdr4_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        sof_d   = sof_q;
        eof_d   = eof_q;
        data_d  = data_q;
        if (adv) begin
            valid_d = 1'b0;
            sof_d   = 1'b0;
            eof_d   = 1'b0;
            case (state_q)
                IDLE: if (wr_tlp_h_valid) begin
                    addr_d  = addr_in;
                    len_d   = wr_tlp_h_len;
                    bef_d   = wr_tlp_h_be_first;
                    bel_d   = wr_tlp_h_be_last;
                    rid_d   = {cfg_bus_number, cfg_device_number, cfg_function_number};
                    hdr4_d  = |addr_in[63:32];
                    cnt_d   = {wr_tlp_h_len == 10'd0, wr_tlp_h_len};
                    valid_d = 1'b1;
                    sof_d   = 1'b1;
                    data_d  = {1'b0, (|addr_in[63:32]) ? 2'b11 : 2'b10, 19'd0, wr_tlp_h_len};
                    state_d = HDR1;
                end
                HDR1: begin
                    valid_d = 1'b1;
                    data_d  = {rid_q, 8'h00, (len_q == 10'd1) ? 4'h0 : bel_q, bef_q};
                    state_d = HDR2;
                end
                HDR2: begin
                    valid_d = 1'b1;
                    data_d  = hdr4_q ? addr_q[63:32] : {addr_q[31:2], 2'b00};
                    state_d = hdr4_q ? HDR3 : DATA;
                end
                HDR3: begin
                    valid_d = 1'b1;
                    data_d  = {addr_q[31:2], 2'b00};
                    state_d = DATA;
                end
                DATA: if (wr_tlp_d_valid) begin
                    valid_d = 1'b1;
                    data_d  = wr_tlp_d_data;
                    eof_d   = cnt_q == 11'd1;
                    cnt_d   = cnt_q - 11'd1;
                    state_d = (cnt_q == 11'd1) ? IDLE : DATA;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            bef_q   <= '0;
            bel_q   <= '0;
            rid_q   <= '0;
            hdr4_q  <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            bef_q   <= bef_d;
            bel_q   <= bel_d;
            rid_q   <= rid_d;
            hdr4_q  <= hdr4_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_write_fmt.sv
// tb_dlsc_pcie_s6_outbound_write_fmt: TLP-level model and scoreboard for the outbound write formatter
module tb_dlsc_pcie_s6_outbound_write_fmt;
    typedef struct {logic [63:0] a; logic [9:0] len; logic [3:0] bf, bl; logic [7:0] bus; logic [4:0] dev; logic [2:0] fn;} hdr_t;
    typedef struct {logic [31:0] d; logic sof, eof;} word_t;

    logic clk = 0, rst = 1;
    logic [7:0] cfg_bus_number = 0;
    logic [4:0] cfg_device_number = 0;
    logic [2:0] cfg_function_number = 0;
    logic wr_tlp_h_ready, wr_tlp_h_valid = 0;
    logic [63:2] wr_tlp_h_addr = 0;
    logic [9:0] wr_tlp_h_len = 0;
    logic [3:0] wr_tlp_h_be_first = 0, wr_tlp_h_be_last = 0;
    logic wr_tlp_d_ready, wr_tlp_d_valid = 0;
    logic [31:0] wr_tlp_d_data = 0;
    logic tx_ready = 1, tx_valid, tx_sof, tx_eof;
    logic [31:0] tx_data;

    dlsc_pcie_s6_outbound_write_fmt #(.ADDR(64)) dut (
        .clk(clk), .rst(rst),
        .cfg_bus_number(cfg_bus_number), .cfg_device_number(cfg_device_number),
        .cfg_function_number(cfg_function_number),
        .wr_tlp_h_ready(wr_tlp_h_ready), .wr_tlp_h_valid(wr_tlp_h_valid),
        .wr_tlp_h_addr(wr_tlp_h_addr), .wr_tlp_h_len(wr_tlp_h_len),
        .wr_tlp_h_be_first(wr_tlp_h_be_first), .wr_tlp_h_be_last(wr_tlp_h_be_last),
        .wr_tlp_d_ready(wr_tlp_d_ready), .wr_tlp_d_valid(wr_tlp_d_valid), .wr_tlp_d_data(wr_tlp_d_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_sof(tx_sof), .tx_eof(tx_eof)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int rdy_pct = 100, dv_pct = 100;
    hdr_t hq[$];
    logic [31:0] dq[$];
    word_t exp_q[$];
    int hacc_q[$], sof_q[$], eof_q[$];
    bit h_fire = 0, d_fire = 0, hold = 0;
    logic [31:0] held_d;
    logic held_s, held_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Expected TLP words derived from the Memory Write header layout
    task automatic add_tlp(input logic [63:0] a, input logic [9:0] len, input logic [3:0] bf, input logic [3:0] bl,
                           input logic [7:0] bus, input logic [4:0] dev, input logic [2:0] fn, input bit rnd);
        int n = (len == 0) ? 1024 : int'(len);
        bit four = a[63:32] != 0;
        hdr_t h;
        logic [31:0] d;
        h.a = a; h.len = len; h.bf = bf; h.bl = bl; h.bus = bus; h.dev = dev; h.fn = fn;
        exp_q.push_back('{(four ? 32'h6000_0000 : 32'h4000_0000) + 32'(len), 1'b1, 1'b0});
        exp_q.push_back('{{bus, dev, fn, 8'h00, (n == 1) ? 4'h0 : bl, bf}, 1'b0, 1'b0});
        if (four) exp_q.push_back('{a[63:32], 1'b0, 1'b0});
        exp_q.push_back('{a[31:0] & 32'hFFFF_FFFC, 1'b0, 1'b0});
        for (int i = 0; i < n; i++) begin
            d = rnd ? $urandom : 32'hD000_0000 + i;
            dq.push_back(d);
            exp_q.push_back('{d, 1'b0, i == n - 1});
        end
        hq.push_back(h);
    endtask

    task automatic drain(input string name);
        int t;
        for (t = 0; t < 5000; t++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && hq.size() == 0 && dq.size() == 0) break;
        end
        n_chk++;
        if (t == 5000) begin
            n_fail++;
            $display("FAIL %s_drain: %0d words still expected, required 0", name, exp_q.size());
        end
        repeat (2) @(posedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk); #1;
        tx_ready = $urandom_range(99) < rdy_pct;
        if (h_fire && hq.size() > 0) void'(hq.pop_front());
        if (d_fire && dq.size() > 0) void'(dq.pop_front());
        wr_tlp_h_valid = hq.size() > 0;
        if (hq.size() > 0) begin
            wr_tlp_h_addr = hq[0].a[63:2]; wr_tlp_h_len = hq[0].len;
            wr_tlp_h_be_first = hq[0].bf; wr_tlp_h_be_last = hq[0].bl;
            cfg_bus_number = hq[0].bus; cfg_device_number = hq[0].dev; cfg_function_number = hq[0].fn;
        end
        wr_tlp_d_valid = dq.size() > 0 && $urandom_range(99) < dv_pct;
        if (dq.size() > 0) wr_tlp_d_data = dq[0];
    end

    always @(negedge clk) begin
        word_t e;
        h_fire = !rst && wr_tlp_h_valid && wr_tlp_h_ready;
        d_fire = !rst && wr_tlp_d_valid && wr_tlp_d_ready;
        if (rst) hold = 0;
        else begin
            if (h_fire) hacc_q.push_back(cyc);
            if (hold) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, held_d);
                chk("hold_flags", {tx_sof, tx_eof}, {held_s, held_e});
            end
            if (tx_valid) chk("sof_eof_excl", tx_sof & tx_eof, 0);
            if (tx_valid && tx_ready) begin
                if (tx_sof) sof_q.push_back(cyc);
                if (tx_eof) eof_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_word: got %h expected none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_word", {tx_sof, tx_eof, tx_data}, {e.sof, e.eof, e.d});
                end
            end
            hold = tx_valid && !tx_ready;
            held_d = tx_data; held_s = tx_sof; held_e = tx_eof;
        end
    end

    task automatic clear_cyc();
        hacc_q.delete(); sof_q.delete(); eof_q.delete();
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_tx"}, {tx_valid, tx_sof, tx_eof, tx_data}, 35'd0);
        chk({name, "_ready"}, {wr_tlp_h_ready, wr_tlp_d_ready}, 2'b10);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk_reset_state("reset");
        rst = 0;
        @(posedge clk);

        clear_cyc();
        add_tlp(64'h1000, 10'd1, 4'hF, 4'hF, 8'h01, 5'h02, 3'h3, 0);
        chk("model_dw0", exp_q[0].d, 32'h4000_0001);
        chk("model_dw1", exp_q[1].d, 32'h0113_000F);
        chk("model_dw2", exp_q[2].d, 32'h0000_1000);
        chk("model_words", exp_q.size(), 4);
        drain("t3dw");
        chk("lat_sof", sof_q[0] - hacc_q[0], 1);
        chk("lat_eof", eof_q[0] - hacc_q[0], 4);

        add_tlp(64'h1_2345_6780, 10'd4, 4'h3, 4'hC, 8'hA5, 5'h1F, 3'h7, 0);
        chk("model4_dw0", exp_q[0].d, 32'h6000_0004);
        chk("model4_dw1", exp_q[1].d, 32'hA5FF_00C3);
        chk("model4_dw2", exp_q[2].d, 32'h0000_0001);
        chk("model4_dw3", exp_q[3].d, 32'h2345_6780);
        drain("t4dw");

        clear_cyc();
        add_tlp(64'h2000_0000, 10'd0, 4'hF, 4'h1, 8'h10, 5'h03, 3'h0, 1);
        chk("model0_dw0", exp_q[0].d, 32'h4000_0000);
        chk("model0_words", exp_q.size(), 1027);
        drain("tlen0");
        chk("len0_eofs", eof_q.size(), 1);
        chk("len0_span", eof_q[0] - sof_q[0], 1026);

        clear_cyc();
        add_tlp(64'h0000_0040, 10'd2, 4'hE, 4'h7, 8'h02, 5'h04, 3'h1, 1);
        add_tlp(64'hF_0000_0080, 10'd3, 4'hF, 4'hF, 8'h03, 5'h05, 3'h2, 1);
        drain("tb2b");
        chk("b2b_gap", sof_q[1] - eof_q[0], 1);
        chk("b2b_span", eof_q[1] - sof_q[0], 11);

        rdy_pct = 60; dv_pct = 60;
        for (int i = 0; i < 6; i++)
            add_tlp({($urandom_range(1) != 0) ? 32'($urandom_range(255)) : 32'h0, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC,
                    10'($urandom_range(20, 1)), 4'($urandom), 4'($urandom), 8'($urandom), 5'($urandom), 3'($urandom), 1);
        drain("trand");
        rdy_pct = 100; dv_pct = 100;

        add_tlp(64'h3000, 10'd50, 4'hF, 4'hF, 8'h07, 5'h08, 3'h4, 0);
        for (int t = 0; t < 200 && dq.size() > 40; t++) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #2;
        chk_reset_state("midrst");
        hq.delete(); dq.delete(); exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        add_tlp(64'h4_0000_1230, 10'd2, 4'h8, 4'h1, 8'h09, 5'h0A, 3'h5, 0);
        chk("modelr_dw0", exp_q[0].d, 32'h6000_0002);
        drain("tpostrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
